rc4_decrypt_msg: RTL and testbench
==================================

Name: rc4_decrypt_msg

Overview:
- Downstream consumer of the 32-byte encrypted-message register array produced by the ROM-read stage.
- Runs the RC4 PRGA over an already key-scheduled 256x8 S memory (single-port synchronous RAM).
- XORs each keystream byte with the matching encrypted byte and writes the plaintext to a 32x8 decrypted-message RAM.
- Flags whether every plaintext byte is a lowercase letter or a space; the key-search controller uses this flag to accept or reject a key.

Parameters:
- MSG_LEN, 32: number of message bytes to decrypt (1..32).
- RD_WAIT, 1: wait cycles between driving s_address and sampling s_q (1..3).
- ABORT_ON_INVALID, 1: 1 = stop after the first invalid plaintext byte; 0 = always process MSG_LEN bytes.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- start  in  1  level request; held high until done, then dropped.
- rom_data  in  8 x [31:0]  encrypted message bytes; index k is byte k.
- s_address  out  8  S RAM address.
- s_data  out  8  S RAM write data.
- s_wren  out  1  S RAM write enable.
- s_q  in  8  S RAM read data.
- d_address  out  5  decrypted RAM address.
- d_data  out  8  decrypted RAM write data.
- d_wren  out  1  decrypted RAM write enable.
- done  out  1  high while in DONE.
- msg_valid  out  1  1 = all written bytes valid; meaningful only while done is high.

Behaviour:
- Reset (asynchronous, reset low): state=IDLE; i, j, k, si, sj, f, wait counter=0; all outputs 0, including done and msg_valid.
- Register widths:
  - i, j, si, sj, f: 8 bits, mod-256 wrap, no carry kept.
  - k: 5 bits.
- IDLE:
  - On start=1: i<=0, j<=0, k<=0, msg_valid<=1; go to RD_SI.
- Per-byte sequence, one state per cycle unless noted:
  - RD_SI: s_address=i+1; i<=i+1.
  - WAIT1: held for RD_WAIT cycles.
  - CAP_SI: si<=s_q; j<=j+s_q.
  - RD_SJ: s_address=j.
  - WAIT2: held for RD_WAIT cycles.
  - CAP_SJ: sj<=s_q.
  - WR_SI: s_address=i, s_data=sj, s_wren=1.
  - WR_SJ: s_address=j, s_data=si, s_wren=1.
  - RD_F: s_address=si+sj.
  - WAIT3: held for RD_WAIT cycles.
  - CAP_F: f<=s_q.
  - WR_D: d_address=k, d_data=f^rom_data[k], d_wren=1; msg_valid<=0 if the byte is not in 0x61..0x7A and not 0x20.
  - NEXT: if k==MSG_LEN-1, or (ABORT_ON_INVALID and msg_valid==0), go to DONE; else k<=k+1 and go to RD_SI.
- Cycles per byte: 10+3*RD_WAIT (13 at default).
  - The state enters DONE exactly MSG_LEN*(10+3*RD_WAIT) edges after the edge that sampled start in IDLE.
- Write-enable rules:
  - s_wren and d_wren are high only in their write states.
  - s_data and d_data hold don't-care values when not writing; the bench must not check them then.
- i==j: both swap writes hit the same address with the same value; no special case.
- RD_F address uses the captured pre-swap si and sj; the sum is identical after the swap.
- DONE: done=1 and msg_valid held. On start=0, go to IDLE (done drops next cycle). A new start re-runs from i=j=0; re-initialising S is the upstream stage's job.
- reset low in any state: immediate return to IDLE with the reset values above. An interrupted swap may leave S corrupted; this is acceptable and the controller re-initialises S.
- start dropped mid-run: ignored; the run completes.

Decomposition:
- Package rc4_pkg:
  - MSG_LEN_MAX=32, S_SIZE=256.
  - State enum (15 states above).
  - Function is_valid_char(byte) returning (byte>=8'h61 && byte<=8'h7A) || byte==8'h20.
- No sub-module. The RD_WAIT counter and char check live inline in the FSM block.

Test Plan:
- Identity S (s[x]=x), rom_data all 0, ABORT_ON_INVALID=0 -> d writes 02,05,07,... for k=0,1,2 matching the bench RC4 model; msg_valid=0 at done.
- Identity S, rom_data[k]=model_keystream[k]^8'h61 -> 32 d writes of 8'h61 at addresses 0..31; msg_valid=1; final S equals the model's S.
- Same as the first scenario with ABORT_ON_INVALID=1 -> exactly one d_wren pulse (address 0, data 02); done rises 13 edges after start; msg_valid=0.
- Last-byte boundary: plaintext[31] of 8'h20, then 8'h7A, then 8'h60, then 8'h7B -> msg_valid 1, 1, 0, 0; with 8'h60, 32 writes still occur because the abort decision falls at k==31.
- Timing: RD_WAIT=1 -> done at edge 416 after start; RD_WAIT=2 -> edge 512; done drops one cycle after start goes low.
- Reset low asserted during WR_SI of byte 5 -> s_wren, d_wren and done go 0 without a clock edge. Release reset, reload S, assert start -> full correct run from k=0.

Source files
------------

// File: rtl/rc4_pkg.sv
// Shared types and helpers for the RC4 message-decrypt stage.
package rc4_pkg;

    localparam int unsigned MSG_LEN_MAX = 32;
    localparam int unsigned S_SIZE      = 256;

    // One state per PRGA micro-step, plus IDLE and DONE.
    typedef enum logic [3:0] {
        IDLE,
        RD_SI,
        WAIT1,
        CAP_SI,
        RD_SJ,
        WAIT2,
        CAP_SJ,
        WR_SI,
        WR_SJ,
        RD_F,
        WAIT3,
        CAP_F,
        WR_D,
        NEXT,
        DONE
    } state_t;

    // Plaintext is accepted only if it is a lowercase letter or a space.
    function automatic logic is_valid_char(input logic [7:0] b);
        return ((b >= 8'h61) && (b <= 8'h7A)) || (b == 8'h20);
    endfunction

endpackage

// File: rtl/rc4_decrypt_msg.sv
// RC4 PRGA over a pre-scheduled S RAM; XORs the keystream with the encrypted
// message, writes plaintext to the decrypted-message RAM and flags validity.
module rc4_decrypt_msg
    import rc4_pkg::*;
#(
    parameter int unsigned MSG_LEN          = 32,
    parameter int unsigned RD_WAIT          = 1,
    parameter int unsigned ABORT_ON_INVALID = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [MSG_LEN_MAX-1:0][7:0]   rom_data,
    output logic [7:0]                    s_address,
    output logic [7:0]                    s_data,
    output logic                          s_wren,
    input  logic [7:0]                    s_q,
    output logic [4:0]                    d_address,
    output logic [7:0]                    d_data,
    output logic                          d_wren,
    output logic                          done,
    output logic                          msg_valid
);

    state_t      r_state;
    state_t      w_next;

    logic [7:0]  r_i;
    logic [7:0]  r_j;
    logic [7:0]  r_si;
    logic [7:0]  r_sj;
    logic [7:0]  r_f;
    logic [4:0]  r_k;
    logic [1:0]  r_wait;
    logic        r_msg_valid;

    logic [7:0]  w_plain;
    logic [7:0]  w_f_addr;
    logic        w_wait_last;
    logic        w_finish;

    assign w_plain     = r_f ^ rom_data[r_k];
    assign w_f_addr    = r_si + r_sj;
    assign w_wait_last = (r_wait == 2'(RD_WAIT - 1));
    assign w_finish    = (r_k == 5'(MSG_LEN - 1)) ||
                         ((ABORT_ON_INVALID != 0) && !r_msg_valid);
    assign msg_valid   = r_msg_valid;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // PRGA datapath: indices, captured S values, wait counter, validity flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_i         <= '0;
            r_j         <= '0;
            r_si        <= '0;
            r_sj        <= '0;
            r_f         <= '0;
            r_k         <= '0;
            r_wait      <= '0;
            r_msg_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_i         <= '0;
                    r_j         <= '0;
                    r_k         <= '0;
                    r_wait      <= '0;
                    r_msg_valid <= 1'b1;
                end
                RD_SI:  r_i <= r_i + 8'd1;
                WAIT1, WAIT2, WAIT3:
                    r_wait <= w_wait_last ? '0 : r_wait + 2'd1;
                CAP_SI: begin
                    r_si <= s_q;
                    r_j  <= r_j + s_q;
                end
                CAP_SJ: r_sj <= s_q;
                CAP_F:  r_f  <= s_q;
                WR_D:   if (!is_valid_char(w_plain)) r_msg_valid <= 1'b0;
                NEXT:   if (!w_finish) r_k <= r_k + 5'd1;
                default: ;
            endcase
        end
    end

    // Next-state and RAM strobes; read addresses are held through the wait
    // states so RAMs with an output register still see a stable address.
    always_comb begin
        w_next    = r_state;
        s_address = '0;
        s_data    = '0;
        s_wren    = 1'b0;
        d_address = '0;
        d_data    = '0;
        d_wren    = 1'b0;
        done      = 1'b0;
        case (r_state)
            IDLE:   if (start) w_next = RD_SI;
            RD_SI:  begin s_address = r_i + 8'd1; w_next = WAIT1; end
            WAIT1:  begin s_address = r_i; if (w_wait_last) w_next = CAP_SI; end
            CAP_SI: begin s_address = r_i; w_next = RD_SJ; end
            RD_SJ:  begin s_address = r_j; w_next = WAIT2; end
            WAIT2:  begin s_address = r_j; if (w_wait_last) w_next = CAP_SJ; end
            CAP_SJ: begin s_address = r_j; w_next = WR_SI; end
            WR_SI:  begin s_address = r_i; s_data = r_sj; s_wren = 1'b1; w_next = WR_SJ; end
            WR_SJ:  begin s_address = r_j; s_data = r_si; s_wren = 1'b1; w_next = RD_F; end
            RD_F:   begin s_address = w_f_addr; w_next = WAIT3; end
            WAIT3:  begin s_address = w_f_addr; if (w_wait_last) w_next = CAP_F; end
            CAP_F:  begin s_address = w_f_addr; w_next = WR_D; end
            WR_D:   begin
                d_address = r_k;
                d_data    = w_plain;
                d_wren    = 1'b1;
                w_next    = NEXT;
            end
            NEXT:   w_next = w_finish ? DONE : RD_SI;
            DONE:   begin done = 1'b1; if (!start) w_next = IDLE; end
            default: w_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_rc4_decrypt_msg.sv
// Directed bench: three instances (abort off / abort on / RD_WAIT=2) share
// stimulus; each has its own synchronous S RAM model and an RC4 reference.
module tb_rc4_decrypt_msg;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic ld;
    logic [31:0][7:0] rom;

    logic [7:0] sa0, sd0, q0, sa1, sd1, q1, sa2, sd2, q2;
    logic       sw0, sw1, sw2, dw0, dw1, dw2;
    logic [4:0] da0, da1, da2;
    logic [7:0] dd0, dd1, dd2;
    logic       done0, done1, done2, mv0, mv1, mv2;

    logic [7:0] m0 [256];
    logic [7:0] m1 [256];
    logic [7:0] m2 [256];

    logic [4:0] la0 [512];
    logic [7:0] lg0 [512];
    logic [4:0] la1 [512];
    logic [7:0] lg1 [512];
    int wc0 = 0;
    int wc1 = 0;

    logic [7:0] s_m  [256];
    logic [7:0] ks_m [32];

    int nchk = 0;
    int npass = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    rc4_decrypt_msg #(.MSG_LEN(32), .RD_WAIT(1), .ABORT_ON_INVALID(0)) u_dut0 (
        .clk(clk), .reset(reset), .start(start), .rom_data(rom),
        .s_address(sa0), .s_data(sd0), .s_wren(sw0), .s_q(q0),
        .d_address(da0), .d_data(dd0), .d_wren(dw0),
        .done(done0), .msg_valid(mv0));

    rc4_decrypt_msg #(.MSG_LEN(32), .RD_WAIT(1), .ABORT_ON_INVALID(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start), .rom_data(rom),
        .s_address(sa1), .s_data(sd1), .s_wren(sw1), .s_q(q1),
        .d_address(da1), .d_data(dd1), .d_wren(dw1),
        .done(done1), .msg_valid(mv1));

    rc4_decrypt_msg #(.MSG_LEN(32), .RD_WAIT(2), .ABORT_ON_INVALID(0)) u_dut2 (
        .clk(clk), .reset(reset), .start(start), .rom_data(rom),
        .s_address(sa2), .s_data(sd2), .s_wren(sw2), .s_q(q2),
        .d_address(da2), .d_data(dd2), .d_wren(dw2),
        .done(done2), .msg_valid(mv2));

    // S RAM models: one-cycle synchronous read, ld loads identity.
    always @(posedge clk) begin
        if (ld) for (int x = 0; x < 256; x++) m0[x] <= 8'(x);
        else if (sw0) m0[sa0] <= sd0;
        q0 <= m0[sa0];
    end
    always @(posedge clk) begin
        if (ld) for (int x = 0; x < 256; x++) m1[x] <= 8'(x);
        else if (sw1) m1[sa1] <= sd1;
        q1 <= m1[sa1];
    end
    always @(posedge clk) begin
        if (ld) for (int x = 0; x < 256; x++) m2[x] <= 8'(x);
        else if (sw2) m2[sa2] <= sd2;
        q2 <= m2[sa2];
    end

    // Decrypted-RAM write loggers.
    always @(negedge clk) begin
        if (dw0) begin
            la0[wc0 % 512] <= da0;
            lg0[wc0 % 512] <= dd0;
            wc0 <= wc0 + 1;
        end
        if (dw1) begin
            la1[wc1 % 512] <= da1;
            lg1[wc1 % 512] <= dd1;
            wc1 <= wc1 + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference RC4 PRGA from identity S, 32 bytes.
    task automatic model();
        logic [7:0] i, j, t, a;
        for (int x = 0; x < 256; x++) s_m[x] = 8'(x);
        i = 8'd0;
        j = 8'd0;
        for (int k = 0; k < 32; k++) begin
            i = i + 8'd1;
            j = j + s_m[i];
            t = s_m[i];
            s_m[i] = s_m[j];
            s_m[j] = t;
            a = s_m[i] + s_m[j];
            ks_m[k] = s_m[a];
        end
    endtask

    task automatic load_s();
        ld = 1'b1;
        @(posedge clk); #1;
        ld = 1'b0;
    endtask

    // Start all three, record done edge (counted from the sampling edge).
    task automatic run(output int t0, output int t1, output int t2, output logic [2:0] mv);
        t0 = 0; t1 = 0; t2 = 0;
        mv = 3'b000;
        start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 700; c++) begin
            @(posedge clk); #1;
            if (done0 && t0 == 0) t0 = c;
            if (done1 && t1 == 0) t1 = c;
            if (done2 && t2 == 0) t2 = c;
            if (t0 != 0 && t1 != 0 && t2 != 0) break;
        end
        mv = {mv0, mv1, mv2};
        start = 1'b0;
        @(posedge clk); #1;
        chk("done_drop", 32'({done0, done1, done2}), 32'd0);
    endtask

    task automatic chk_log0(input string tag, input int b, input bit plain);
        int bad = 0;
        for (int k = 0; k < 32; k++) begin
            if (la0[(b + k) % 512] !== 5'(k)) bad++;
            if (lg0[(b + k) % 512] !== (plain ? 8'h61 : ks_m[k])) bad++;
        end
        chk(tag, 32'(bad), 32'd0);
    endtask

    task automatic chk_s0(input string tag);
        int bad = 0;
        for (int x = 0; x < 256; x++) if (m0[x] !== s_m[x]) bad++;
        chk(tag, 32'(bad), 32'd0);
    endtask

    logic [7:0] bp [4] = '{8'h20, 8'h7A, 8'h60, 8'h7B};
    logic [2:0] bv [4] = '{3'b111, 3'b111, 3'b000, 3'b000};

    initial begin
        int b0, b1, t0, t1, t2;
        logic [2:0] mv;
        bit found;

        reset = 1'b0;
        start = 1'b0;
        ld    = 1'b0;
        rom   = '0;
        model();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_done",  32'(done0), 32'd0);
        chk("rst_mv",    32'(mv0), 32'd0);
        chk("rst_swren", 32'(sw0), 32'd0);
        chk("rst_dwren", 32'(dw0), 32'd0);
        chk("rst_saddr", 32'(sa0), 32'd0);
        chk("rst_daddr", 32'(da0), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Identity S, all-zero ciphertext: plaintext = raw keystream.
        load_s();
        b0 = wc0; b1 = wc1;
        run(t0, t1, t2, mv);
        chk("A_wcount0", 32'(wc0 - b0), 32'd32);
        chk("A_ks0", 32'(lg0[b0 % 512]), 32'h02);
        chk("A_ks1", 32'(lg0[(b0 + 1) % 512]), 32'h05);
        chk("A_ks2", 32'(lg0[(b0 + 2) % 512]), 32'h07);
        chk_log0("A_seq0", b0, 1'b0);
        chk("A_mv", 32'(mv), 32'd0);
        chk("A_t0", 32'(t0), 32'd416);
        chk("A_t1_abort", 32'(t1), 32'd13);
        chk("A_t2_wait2", 32'(t2), 32'd512);
        chk("A_wcount1", 32'(wc1 - b1), 32'd1);
        chk("A_addr1", 32'(la1[b1 % 512]), 32'd0);
        chk("A_data1", 32'(lg1[b1 % 512]), 32'h02);
        chk_s0("A_final_S");

        // Ciphertext that decrypts to all 'a'.
        for (int k = 0; k < 32; k++) rom[k] = ks_m[k] ^ 8'h61;
        load_s();
        b0 = wc0; b1 = wc1;
        run(t0, t1, t2, mv);
        chk("B_wcount0", 32'(wc0 - b0), 32'd32);
        chk_log0("B_seq0", b0, 1'b1);
        chk("B_mv", 32'(mv), 32'b111);
        chk("B_t0", 32'(t0), 32'd416);
        chk("B_t1", 32'(t1), 32'd416);
        chk("B_wcount1", 32'(wc1 - b1), 32'd32);
        chk_s0("B_final_S");

        // Last-byte character-class boundaries.
        for (int n = 0; n < 4; n++) begin
            rom[31] = ks_m[31] ^ bp[n];
            load_s();
            b1 = wc1;
            run(t0, t1, t2, mv);
            chk($sformatf("bnd%0d_mv", n), 32'(mv), 32'(bv[n]));
            chk($sformatf("bnd%0d_wcount1", n), 32'(wc1 - b1), 32'd32);
        end

        // Asynchronous reset during WR_SI of byte 5, then a clean rerun.
        rom[31] = ks_m[31] ^ 8'h61;
        load_s();
        b0 = wc0;
        found = 1'b0;
        start = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            if ((wc0 - b0) == 5 && sw0) begin
                found = 1'b1;
                break;
            end
        end
        chk("R_found_wrsi", 32'(found), 32'd1);
        reset = 1'b0;
        #1;
        chk("R_swren", 32'(sw0), 32'd0);
        chk("R_dwren", 32'(dw0), 32'd0);
        chk("R_done",  32'(done0), 32'd0);
        chk("R_saddr", 32'(sa0), 32'd0);
        start = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        load_s();
        b0 = wc0;
        run(t0, t1, t2, mv);
        chk("R_wcount0", 32'(wc0 - b0), 32'd32);
        chk_log0("R_seq0", b0, 1'b1);
        chk("R_mv", 32'(mv), 32'b111);
        chk("R_t0", 32'(t0), 32'd416);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
